// File: rtl/timer_irq_ctrl.sv
// Host-side sequencer for the down_counter timer: takes a mode/reload configuration,
// loads and starts the timer, and turns its interrupt edges into a maskable IRQ with event/miss counters.
module timer_irq_ctrl #(
   parameter int CNT_W  = 16,
   parameter int EVT_W  = 16,
   parameter int MISS_W = 8
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [1:0]        cfg_mode_i,
   input  logic [CNT_W-1:0]  cfg_load_i,
   input  logic              cfg_stop_i,
   output logic              cfg_err_o,
   output logic              tmr_load_en_o,
   output logic [CNT_W-1:0]  tmr_load_o,
   output logic [1:0]        tmr_mode_o,
   output logic              tmr_start_o,
   input  logic              tmr_interrupt_i,
   input  logic              irq_mask_i,
   input  logic              irq_ack_i,
   output logic              irq_o,
   output logic              pending_o,
   output logic [EVT_W-1:0]  event_cnt_o,
   output logic [MISS_W-1:0] miss_cnt_o
);

   // state | meaning
   // IDLE  | no timer activity, configuration accepted
   // LOAD  | one-cycle load strobe to the timer
   // RUN   | timer enabled, interrupt edges counted as events
   // DONE  | single-shot expired, configuration accepted again
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   localparam logic [1:0] MODE_SINGLE = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   state_t             state_q;
   logic               int_q;
   logic               cfg_err_q;
   logic               tmr_load_en_q;
   logic [CNT_W-1:0]   tmr_load_q;
   logic [1:0]         tmr_mode_q;
   logic               tmr_start_q;
   logic               pending_q;
   logic [EVT_W-1:0]   event_cnt_q;
   logic [MISS_W-1:0]  miss_cnt_q;
   logic               evt_d;

   // Edge register runs in every state so a level already high at RUN entry is not an event.
   assign evt_d = (state_q == S_RUN) && tmr_interrupt_i && !int_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         int_q         <= 1'b0;
         cfg_err_q     <= 1'b0;
         tmr_load_en_q <= 1'b0;
         tmr_load_q    <= '0;
         tmr_mode_q    <= '0;
         tmr_start_q   <= 1'b0;
         pending_q     <= 1'b0;
         event_cnt_q   <= '0;
         miss_cnt_q    <= '0;
      end else begin
         int_q         <= tmr_interrupt_i;
         cfg_err_q     <= 1'b0;
         tmr_load_en_q <= 1'b0;

         if (evt_d) begin
            event_cnt_q <= event_cnt_q + EVT_W'(1);
            if (pending_q && !irq_ack_i && (miss_cnt_q != '1))
               miss_cnt_q <= miss_cnt_q + MISS_W'(1);
            pending_q <= 1'b1;
         end else if (irq_ack_i) begin
            pending_q <= 1'b0;
         end

         case (state_q)
            S_IDLE, S_DONE: begin
               if (cfg_valid_i) begin
                  if (cfg_mode_i == MODE_RSVD) begin
                     cfg_err_q <= 1'b1;
                  end else begin
                     tmr_mode_q    <= cfg_mode_i;
                     tmr_load_q    <= cfg_load_i;
                     event_cnt_q   <= '0;
                     miss_cnt_q    <= '0;
                     tmr_load_en_q <= 1'b1;
                     state_q       <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (cfg_stop_i) begin
                  state_q <= S_IDLE;
               end else begin
                  tmr_start_q <= 1'b1;
                  state_q     <= S_RUN;
               end
            end
            S_RUN: begin
               if (cfg_stop_i) begin
                  tmr_start_q <= 1'b0;
                  state_q     <= S_IDLE;
               end else if (evt_d && (tmr_mode_q == MODE_SINGLE)) begin
                  tmr_start_q <= 1'b0;
                  state_q     <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cfg_ready_o   = (state_q == S_IDLE) || (state_q == S_DONE);
   assign cfg_err_o     = cfg_err_q;
   assign tmr_load_en_o = tmr_load_en_q;
   assign tmr_load_o    = tmr_load_q;
   assign tmr_mode_o    = tmr_mode_q;
   assign tmr_start_o   = tmr_start_q;
   assign pending_o     = pending_q;
   assign irq_o         = pending_q & ~irq_mask_i;
   assign event_cnt_o   = event_cnt_q;
   assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed scenarios followed by random traffic, every cycle compared against
// a behavioural model built from busy/running flags and plain counters.
module tb_timer_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_mode;
   logic [15:0] cfg_load;
   logic        cfg_stop;
   logic        cfg_err;
   logic        tmr_load_en;
   logic [15:0] tmr_load;
   logic [1:0]  tmr_mode;
   logic        tmr_start;
   logic        intr;
   logic        irq_mask;
   logic        irq_ack;
   logic        irq;
   logic        pending;
   logic [15:0] event_cnt;
   logic [7:0]  miss_cnt;

   int checks = 0;
   int errors = 0;

   // Model: "loading" and "running" flags, latched config, counters as ints.
   bit m_loading, m_running, m_err, m_pending, m_prev;
   int m_mode, m_load, m_events, m_miss;

   timer_irq_ctrl #(.CNT_W(16), .EVT_W(16), .MISS_W(8)) dut (
      .clk_i(clk), .reset_i(rst),
      .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
      .cfg_mode_i(cfg_mode), .cfg_load_i(cfg_load), .cfg_stop_i(cfg_stop),
      .cfg_err_o(cfg_err), .tmr_load_en_o(tmr_load_en), .tmr_load_o(tmr_load),
      .tmr_mode_o(tmr_mode), .tmr_start_o(tmr_start),
      .tmr_interrupt_i(intr), .irq_mask_i(irq_mask), .irq_ack_i(irq_ack),
      .irq_o(irq), .pending_o(pending),
      .event_cnt_o(event_cnt), .miss_cnt_o(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("cfg_ready",   32'(cfg_ready),   32'(!m_loading && !m_running));
      chk("cfg_err",     32'(cfg_err),     32'(m_err));
      chk("tmr_load_en", 32'(tmr_load_en), 32'(m_loading));
      chk("tmr_start",   32'(tmr_start),   32'(m_running));
      chk("tmr_load",    32'(tmr_load),    32'(m_load));
      chk("tmr_mode",    32'(tmr_mode),    32'(m_mode));
      chk("pending",     32'(pending),     32'(m_pending));
      chk("irq",         32'(irq),         32'(m_pending && !irq_mask));
      chk("event_cnt",   32'(event_cnt),   32'(m_events));
      chk("miss_cnt",    32'(miss_cnt),    32'(m_miss));
   endtask

   // Advance one clock: derive the model's next values from the current inputs,
   // let the DUT take the edge, then compare shortly after it.
   task automatic step();
      bit ready, evt, n_loading, n_running, n_err, n_pending;
      int n_mode, n_load, n_events, n_miss;
      ready     = !m_loading && !m_running;
      evt       = m_running && intr && !m_prev;
      n_loading = 1'b0;
      n_running = m_running;
      n_err     = 1'b0;
      n_pending = m_pending;
      n_mode    = m_mode;
      n_load    = m_load;
      n_events  = m_events;
      n_miss    = m_miss;
      if (m_loading) n_running = !cfg_stop;
      if (m_running && (cfg_stop || (evt && m_mode == 2))) n_running = 1'b0;
      if (evt) begin
         n_events = (m_events + 1) % 65536;
         if (m_pending && !irq_ack && m_miss < 255) n_miss = m_miss + 1;
         n_pending = 1'b1;
      end else if (irq_ack) begin
         n_pending = 1'b0;
      end
      if (ready && cfg_valid) begin
         if (cfg_mode == 2'b11) n_err = 1'b1;
         else begin
            n_loading = 1'b1;
            n_mode    = int'(cfg_mode);
            n_load    = int'(cfg_load);
            n_events  = 0;
            n_miss    = 0;
         end
      end
      if (rst) begin
         n_loading = 0; n_running = 0; n_err = 0; n_pending = 0;
         n_mode = 0; n_load = 0; n_events = 0; n_miss = 0;
      end
      @(posedge clk);
      m_prev    = rst ? 1'b0 : intr;
      m_loading = n_loading;
      m_running = n_running;
      m_err     = n_err;
      m_pending = n_pending;
      m_mode    = n_mode;
      m_load    = n_load;
      m_events  = n_events;
      m_miss    = n_miss;
      #1;
      check_all();
   endtask

   task automatic configure(input logic [1:0] mode, input logic [15:0] load);
      cfg_valid = 1'b1; cfg_mode = mode; cfg_load = load;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_int();
      intr = 1'b1; step();
      intr = 1'b0; step();
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_load = 16'd0;
      cfg_stop = 1'b0; intr = 1'b0; irq_mask = 1'b0; irq_ack = 1'b0;
      m_loading = 0; m_running = 0; m_err = 0; m_pending = 0; m_prev = 0;
      m_mode = 0; m_load = 0; m_events = 0; m_miss = 0;
      repeat (3) step();
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_start", 32'(tmr_start), 32'd0);
      rst = 1'b0;
      step();

      // Cyclic config: strobe at N+1, run from N+2
      configure(2'b01, 16'd10);
      chk("t1_load_en", 32'(tmr_load_en), 32'd1);
      chk("t1_load",    32'(tmr_load),    32'd10);
      chk("t1_ready",   32'(cfg_ready),   32'd0);
      step();
      chk("t1_start",   32'(tmr_start),   32'd1);
      chk("t1_load_en_once", 32'(tmr_load_en), 32'd0);
      cfg_stop = 1'b1; step(); cfg_stop = 1'b0;

      // Free-running: three events unacked, then masking, then ack/event overlap
      configure(2'b00, 16'd5);
      step();
      repeat (3) pulse_int();
      chk("t2_events",  32'(event_cnt), 32'd3);
      chk("t2_miss",    32'(miss_cnt),  32'd2);
      chk("t2_irq",     32'(irq),       32'd1);
      irq_mask = 1'b1; #1;
      chk("t2_masked",  32'(irq),       32'd0);
      chk("t2_pend",    32'(pending),   32'd1);
      step(); irq_mask = 1'b0;
      intr = 1'b1; irq_ack = 1'b1; step();
      intr = 1'b0; irq_ack = 1'b0;
      chk("t4_pend",    32'(pending),   32'd1);
      chk("t4_miss",    32'(miss_cnt),  32'd2);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      chk("t4_cleared", 32'(pending),   32'd0);
      cfg_stop = 1'b1; step(); cfg_stop = 1'b0;

      // Single-shot: first event ends the run, later edges ignored
      configure(2'b10, 16'd3);
      step();
      intr = 1'b1; step();
      chk("t3_start",   32'(tmr_start), 32'd0);
      chk("t3_ready",   32'(cfg_ready), 32'd1);
      intr = 1'b0; step();
      repeat (2) pulse_int();
      chk("t3_events",  32'(event_cnt), 32'd1);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;

      // Reserved mode rejected, then miss counter saturation
      configure(2'b11, 16'd99);
      chk("t5_err",     32'(cfg_err),     32'd1);
      chk("t5_no_load", 32'(tmr_load_en), 32'd0);
      step();
      chk("t5_err_pulse", 32'(cfg_err),   32'd0);
      configure(2'b00, 16'd8);
      step();
      repeat (300) pulse_int();
      chk("t5_miss_sat", 32'(miss_cnt),  32'd255);
      chk("t5_events",   32'(event_cnt), 32'd300);

      // Stop in RUN, then reset in the middle of a run
      cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
      chk("t6_stop_start", 32'(tmr_start), 32'd0);
      chk("t6_stop_ready", 32'(cfg_ready), 32'd1);
      configure(2'b01, 16'd7);
      step(); step();
      rst = 1'b1; step(); rst = 1'b0;
      chk("t6_rst_start", 32'(tmr_start), 32'd0);
      chk("t6_rst_pend",  32'(pending),   32'd0);
      chk("t6_rst_evts",  32'(event_cnt), 32'd0);
      chk("t6_rst_ready", 32'(cfg_ready), 32'd1);

      for (int i = 0; i < 3000; i++) begin
         cfg_valid = ($urandom % 8) == 0;
         cfg_mode  = 2'($urandom % 4);
         cfg_load  = 16'($urandom);
         cfg_stop  = ($urandom % 40) == 0;
         if (($urandom % 3) == 0) intr = ~intr;
         irq_ack   = ($urandom % 7) == 0;
         irq_mask  = ($urandom % 4) == 0;
         rst       = ($urandom % 600) == 0;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
